demapper_rec: RTL
=================

Name: demapper_rec

Overview:
- Receive-side counterpart of the sender chain: recovers 8N1 serial bytes from the line, locks onto the two-byte FAS and captures a fixed-length payload.
- With ARQ enabled, checks the trailing CRC-8 and signals a good frame back to the sender on the ack line.
- Releases verified (or, with ARQ off, unchecked) payload bytes over a valid/ready interface to the UART TX FIFO.

Parameters:
- PAYLOAD_LEN, 16, payload bytes per frame (1..64).
- FAS0, 8'hF6, first frame-alignment byte.
- FAS1, 8'h28, second frame-alignment byte.
- ACK_TICKS, 32, number of 16x-baud ticks the ack line is held high.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset
- i_sclk_en_16_x_baud  in  1  one-cycle tick at 16x line baud
- i_otn_rx_data  in  1  serial line input; idle high; asynchronous
- o_otn_tx_ack  out  1  ack level back to the sender
- i_arq_en  in  1  ARQ enable switch
- o_pyld_data  out  8  payload byte
- o_pyld_data_valid  out  1  payload byte valid
- i_pyld_data_ready  in  1  downstream accepts byte
- o_crc_val  out  8  last computed CRC
- o_crc_err  out  1  one-cycle pulse on CRC mismatch
- o_rx_state  out  3  FSM state encoding
- o_overrun  out  1  one-cycle pulse when a received byte is dropped

Behaviour:
- Reset is i_rst, synchronous, active-high; clock is i_clk.
- Reset values: all outputs 0; FSM in HUNT; synchronizer flops 1; ack counter 0.
- Byte receiver: i_otn_rx_data passes through a 2-flop synchronizer.
  - Acts only on tick cycles.
  - In idle, a low sample starts a tick counter.
  - At count 8 the line must still be low; otherwise it is a glitch and the receiver returns to idle.
  - Data bits are sampled every 16 ticks thereafter, LSB first.
  - The stop bit must be 1; if 0, the byte is discarded silently.
  - A good byte produces a one-cycle byte_valid on the cycle after the stop-bit sample.
- FSM, o_rx_state encoding: HUNT=0, FAS1=1, PAYLOAD=2, CRC=3, RELEASE=4.
  - HUNT: byte==FAS0 -> FAS1; otherwise stay.
  - FAS1: byte==FAS1 -> PAYLOAD, clearing the byte index and CRC register. Byte==FAS0 -> stay in FAS1. Any other byte -> HUNT.
  - PAYLOAD: each byte is written to buffer[index] and folded into the CRC. Index reaches PAYLOAD_LEN-1 -> CRC state if i_arq_en=1, else RELEASE. In the ARQ-off case the CRC byte is not expected.
  - CRC: the received byte is compared with the computed CRC.
    - Match: ack counter loads ACK_TICKS, then RELEASE.
    - Mismatch: one-cycle o_crc_err pulse, buffer discarded, back to HUNT.
  - RELEASE: streams buffer[0..PAYLOAD_LEN-1]. A byte transfers when valid&ready. o_pyld_data_valid stays high and o_pyld_data stays stable until accepted. After the last transfer -> HUNT.
- Bytes completing while in RELEASE are dropped and pulse o_overrun.
- i_arq_en is sampled on entry to PAYLOAD and held for the whole frame.
- CRC-8: polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR. One byte per cycle via an 8-step combinational fold.
- o_crc_val updates in the cycle the CRC-state byte is checked and holds until the next check.
- Ack:
  - o_otn_tx_ack is high while the ack counter is nonzero.
  - The counter decrements on ticks and runs independently of the FSM.
  - No ack is issued on a CRC mismatch or when ARQ is off. The sender retransmits on timeout.
- Reset mid-frame: the buffer contents are abandoned, no ack is issued, and valid drops the next cycle.

Decomposition:
- Shared package holds:
  - state encodings HUNT..RELEASE
  - CRC8_POLY = 8'h07
  - default FAS0/FAS1 constants, also used by the mapper
  - the crc8_next byte-fold function, shared with the mapper
- One sub-module, otn_byte_rx: synchronizer plus 8N1 oversampling receiver. Outputs an 8-bit byte with a one-cycle byte_valid.
- Payload buffer is an inferred array inside demapper_rec.

Test Plan:
- ARQ on, PAYLOAD_LEN=9: send F6 28 "123456789" F4 -> o_crc_val=F4; ack high for 32 ticks; the 9 ASCII bytes emitted in order; no o_crc_err.
- ARQ on, PAYLOAD_LEN=1: send F6 28 01 00 -> o_crc_err pulses once; o_crc_val=07; no ack; no payload output; state returns to 0.
- ARQ off, PAYLOAD_LEN=4: send F6 28 AA BB CC DD -> AA BB CC DD emitted; ack stays 0.
- Hunt: send 00 F6 F6 28 + valid frame -> locks on the second F6 and delivers the frame. Sending F6 11 instead -> stays in HUNT.
- Backpressure: hold i_pyld_data_ready=0 for 50 cycles in RELEASE -> data stable, valid high. A byte arriving meanwhile -> o_overrun pulses once.
- Corrupted stop bit on one payload byte -> byte dropped and the frame length shifts, so the CRC mismatches. Also assert i_rst mid-PAYLOAD -> all outputs 0 next cycle and the next clean frame is received correctly.

Source files
------------

// File: rtl/demapper_rec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demapper_rec_pkg
// Purpose  : Shared frame constants, receive FSM encoding and CRC-8 fold.
// Revision : 1.0
// ============================================================================
package demapper_rec_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_FAS1    = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CRC     = 3'd3,
        ST_RELEASE = 3'd4
    } rx_state_t;

    localparam logic [7:0] CRC8_POLY    = 8'h07;
    localparam logic [7:0] DEFAULT_FAS0 = 8'hF6;
    localparam logic [7:0] DEFAULT_FAS1 = 8'h28;

    // MSB-first, non-reflected: one whole byte folded in per call.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/otn_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : otn_byte_rx
// Purpose  : 2-flop synchronizer plus 16x-oversampling 8N1 byte receiver.
// Revision : 1.0
// ============================================================================
module otn_byte_rx (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid
);

    logic [1:0] r_sync;
    logic       r_busy;
    logic       r_armed;
    logic [3:0] r_tick_cnt;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_byte;
    logic       r_byte_valid;
    logic       w_rx;

    assign w_rx = r_sync[1];

    // A start is only taken after the line has been seen high, so a
    // low (broken) stop bit cannot re-trigger a half-bit-shifted byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync       <= 2'b11;
            r_busy       <= 1'b0;
            r_armed      <= 1'b0;
            r_tick_cnt   <= 4'd0;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_byte       <= 8'h00;
            r_byte_valid <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], i_rx};
            r_byte_valid <= 1'b0;
            if (i_tick) begin
                if (!r_busy) begin
                    if (w_rx) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_busy     <= 1'b1;
                        r_tick_cnt <= 4'd1;
                        r_bit_cnt  <= 4'd0;
                    end
                end else begin
                    r_tick_cnt <= r_tick_cnt + 4'd1;
                    if (r_tick_cnt == 4'd8) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd0) begin
                            if (w_rx) begin
                                r_busy <= 1'b0;
                            end
                        end else if (r_bit_cnt == 4'd9) begin
                            r_busy  <= 1'b0;
                            r_armed <= w_rx;
                            if (w_rx) begin
                                r_byte       <= r_shift;
                                r_byte_valid <= 1'b1;
                            end
                        end else begin
                            r_shift <= {w_rx, r_shift[7:1]};
                        end
                    end
                end
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;

endmodule
`default_nettype wire

// File: rtl/demapper_rec.sv
`default_nettype none
// ============================================================================
// Module   : demapper_rec
// Purpose  : FAS lock, payload capture, CRC-8 check/ack and payload release.
// Revision : 1.0
// ============================================================================
module demapper_rec
    import demapper_rec_pkg::*;
#(
    parameter int         PAYLOAD_LEN = 16,
    parameter logic [7:0] FAS0        = DEFAULT_FAS0,
    parameter logic [7:0] FAS1        = DEFAULT_FAS1,
    parameter int         ACK_TICKS   = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk_en_16_x_baud,
    input  logic       i_otn_rx_data,
    output logic       o_otn_tx_ack,
    input  logic       i_arq_en,
    output logic [7:0] o_pyld_data,
    output logic       o_pyld_data_valid,
    input  logic       i_pyld_data_ready,
    output logic [7:0] o_crc_val,
    output logic       o_crc_err,
    output logic [2:0] o_rx_state,
    output logic       o_overrun
);

    localparam int c_idx_w = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int c_ack_w = $clog2(ACK_TICKS + 1);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PAYLOAD_LEN - 1);

    logic [7:0]         w_byte;
    logic               w_byte_valid;
    rx_state_t          r_state;
    rx_state_t          w_next_state;
    logic [7:0]         r_buf [0:(1<<c_idx_w)-1];
    logic [c_idx_w-1:0] r_wr_idx;
    logic [c_idx_w-1:0] r_rd_idx;
    logic [7:0]         r_crc;
    logic [7:0]         r_crc_val;
    logic               r_crc_err;
    logic               r_overrun;
    logic               r_arq;
    logic [c_ack_w-1:0] r_ack_cnt;
    logic               w_pyld_valid;
    logic               w_xfer;
    logic               w_crc_match;

    otn_byte_rx u_byte_rx (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_tick       (i_sclk_en_16_x_baud),
        .i_rx         (i_otn_rx_data),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid)
    );

    assign w_pyld_valid = (r_state == ST_RELEASE);
    assign w_xfer       = w_pyld_valid && i_pyld_data_ready;
    assign w_crc_match  = (w_byte == r_crc);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_HUNT: begin
                if (w_byte_valid && (w_byte == FAS0)) w_next_state = ST_FAS1;
            end
            ST_FAS1: begin
                if (w_byte_valid) begin
                    if (w_byte == FAS1)      w_next_state = ST_PAYLOAD;
                    else if (w_byte != FAS0) w_next_state = ST_HUNT;
                end
            end
            ST_PAYLOAD: begin
                if (w_byte_valid && (r_wr_idx == c_last_idx))
                    w_next_state = r_arq ? ST_CRC : ST_RELEASE;
            end
            ST_CRC: begin
                if (w_byte_valid) w_next_state = w_crc_match ? ST_RELEASE : ST_HUNT;
            end
            ST_RELEASE: begin
                if (w_xfer && (r_rd_idx == c_last_idx)) w_next_state = ST_HUNT;
            end
            default: w_next_state = ST_HUNT;
        endcase
    end

    // Payload storage is left unreset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (w_byte_valid && (r_state == ST_PAYLOAD)) begin
            r_buf[r_wr_idx] <= w_byte;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_crc     <= 8'h00;
            r_crc_val <= 8'h00;
            r_crc_err <= 1'b0;
            r_overrun <= 1'b0;
            r_arq     <= 1'b0;
            r_ack_cnt <= '0;
        end else begin
            r_crc_err <= 1'b0;
            r_overrun <= 1'b0;
            if (i_sclk_en_16_x_baud && (r_ack_cnt != '0)) begin
                r_ack_cnt <= r_ack_cnt - 1'b1;
            end
            if (w_byte_valid) begin
                case (r_state)
                    ST_FAS1: begin
                        if (w_byte == FAS1) begin
                            r_wr_idx <= '0;
                            r_crc    <= 8'h00;
                            r_arq    <= i_arq_en;
                        end
                    end
                    ST_PAYLOAD: begin
                        r_wr_idx <= r_wr_idx + 1'b1;
                        r_crc    <= crc8_next(r_crc, w_byte);
                    end
                    ST_CRC: begin
                        r_crc_val <= r_crc;
                        if (w_crc_match) r_ack_cnt <= c_ack_w'(ACK_TICKS);
                        else             r_crc_err <= 1'b1;
                    end
                    ST_RELEASE: r_overrun <= 1'b1;
                    default: ;
                endcase
            end
            if (w_xfer) begin
                r_rd_idx <= (r_rd_idx == c_last_idx) ? '0 : (r_rd_idx + 1'b1);
            end
        end
    end

    assign o_otn_tx_ack      = (r_ack_cnt != '0);
    assign o_pyld_data_valid = w_pyld_valid;
    assign o_pyld_data       = w_pyld_valid ? r_buf[r_rd_idx] : 8'h00;
    assign o_crc_val         = r_crc_val;
    assign o_crc_err         = r_crc_err;
    assign o_rx_state        = r_state;
    assign o_overrun         = r_overrun;

endmodule
`default_nettype wire
